nios_fprint_cpu_oci_dct_packer: RTL and testbench

Instruction-trace discontinuity packer for the fprint Nios II OCI debug path. It sits directly upstream of the OCI trace test bench and the trace FIFO. It accepts one 2-bit discontinuity code per cycle from the CPU's trace-control logic and packs up to 15 codes into a 30-bit buffer. It exposes the live accumulator state (`dct_buffer`/`dct_count`) for the test bench monitor and hands completed frames downstream over a valid/ready handshake.

---
 rtl/nios_fprint_oci_pkg.sv | 20 ++
 rtl/nios_fprint_oci_frame_reg.sv | 41 ++++
 rtl/nios_fprint_cpu_oci_dct_packer.sv | 119 +++++++++++
 tb/tb_nios_fprint_cpu_oci_dct_packer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/nios_fprint_oci_pkg.sv
// Shared definitions for the fprint OCI trace packers: frame geometry,
// discontinuity code encoding and packer state encoding.
package nios_fprint_oci_pkg;
  localparam int SLOTS = 15;
  localparam int BUF_W = 2 * SLOTS;
  localparam logic [3:0] FULL_CNT = 4'(SLOTS);

  typedef enum logic [1:0] {
    DCT_BRANCH = 2'd0,
    DCT_CALL   = 2'd1,
    DCT_RETURN = 2'd2,
    DCT_EXC    = 2'd3
  } dct_code_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCUM     = 2'd1,
    ST_FULL_WAIT = 2'd2
  } pk_state_e;
endpackage

// File: rtl/nios_fprint_oci_frame_reg.sv
// One-entry valid/ready output register holding a frame and its code count.
// i_load must only be asserted while o_free is high.
module nios_fprint_oci_frame_reg #(
  parameter int W  = 30,
  parameter int CW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [W-1:0]  i_data,
  input  logic [CW-1:0] i_count,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count,
  output logic          o_free
);
  logic          r_valid;
  logic [W-1:0]  r_data;
  logic [CW-1:0] r_count;

  // The slot is free when empty or draining this cycle, allowing pass-through.
  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_count <= i_count;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/nios_fprint_cpu_oci_dct_packer.sv
// Packs 2-bit trace discontinuity codes into 15-slot frames and hands them
// downstream through a one-entry valid/ready frame register.
module nios_fprint_cpu_oci_dct_packer
  import nios_fprint_oci_pkg::*;
#(
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trc_on,
  input  logic              dct_valid,
  input  logic [1:0]        dct_code,
  input  logic              flush,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [3:0]        dct_count,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [BUF_W-1:0]  frame_data,
  output logic [3:0]        frame_count,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);
  pk_state_e          r_state;
  logic [BUF_W-1:0]   r_buf;
  logic [3:0]         r_cnt;
  logic               r_flush_pend;
  logic               r_overflow;
  logic [DROP_W-1:0]  r_drop;

  pk_state_e          w_nxt_state;
  logic [BUF_W-1:0]   w_post_buf, w_nxt_buf;
  logic [3:0]         w_post_cnt, w_nxt_cnt;
  logic               w_acc, w_full, w_flush_req, w_trc_fall;
  logic               w_nxt_pend, w_load, w_drop, w_free;

  always_comb begin
    w_acc       = (r_state == ST_ACCUM) && trc_on && dct_valid;
    w_post_buf  = r_buf;
    if (w_acc) w_post_buf[{r_cnt, 1'b0} +: 2] = dct_code;
    w_post_cnt  = r_cnt + {3'b000, w_acc};
    w_full      = (w_post_cnt == FULL_CNT);
    // Flush qualifies on the pre-accept count: an empty accumulator never emits.
    w_flush_req = (flush || r_flush_pend) && (r_cnt != 4'd0);
    w_trc_fall  = (r_state == ST_ACCUM) && !trc_on && (r_cnt != 4'd0);

    w_nxt_state = trc_on ? ST_ACCUM : ST_IDLE;
    w_nxt_buf   = w_post_buf;
    w_nxt_cnt   = w_post_cnt;
    w_nxt_pend  = r_flush_pend;
    w_load      = 1'b0;
    w_drop      = 1'b0;

    case (r_state)
      ST_FULL_WAIT: begin
        w_drop = trc_on && dct_valid;
        if (w_free) begin
          w_load     = 1'b1;
          w_nxt_buf  = '0;
          w_nxt_cnt  = 4'd0;
          w_nxt_pend = 1'b0;
        end else begin
          w_nxt_state = ST_FULL_WAIT;
        end
      end
      default: begin
        if (w_full || w_flush_req || w_trc_fall) begin
          if (w_free) begin
            w_load     = 1'b1;
            w_nxt_buf  = '0;
            w_nxt_cnt  = 4'd0;
            w_nxt_pend = 1'b0;
          end else if (w_full) begin
            w_nxt_state = ST_FULL_WAIT;
          end else begin
            w_nxt_pend = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_buf        <= '0;
      r_cnt        <= 4'd0;
      r_flush_pend <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop       <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_buf        <= w_nxt_buf;
      r_cnt        <= w_nxt_cnt;
      r_flush_pend <= w_nxt_pend;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop != {DROP_W{1'b1}}) r_drop <= r_drop + 1'b1;
      end
    end
  end

  nios_fprint_oci_frame_reg #(.W(BUF_W), .CW(4)) u_frame_reg (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_load  (w_load),
    .i_data  (w_post_buf),
    .i_count (w_post_cnt),
    .i_ready (frame_ready),
    .o_valid (frame_valid),
    .o_data  (frame_data),
    .o_count (frame_count),
    .o_free  (w_free)
  );

  assign dct_buffer = r_buf;
  assign dct_count  = r_cnt;
  assign overflow   = r_overflow;
  assign drop_cnt   = r_drop;
endmodule

// File: tb/tb_nios_fprint_cpu_oci_dct_packer.sv
// Directed bench for the discontinuity packer with hand-computed frames.
module tb_nios_fprint_cpu_oci_dct_packer;
  logic        clk = 1'b0;
  logic        reset, trc_on, dct_valid, flush, frame_ready;
  logic [1:0]  dct_code;
  logic [29:0] dct_buffer, frame_data;
  logic [3:0]  dct_count, frame_count;
  logic        frame_valid, overflow;
  logic [7:0]  drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nios_fprint_cpu_oci_dct_packer #(.DROP_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .trc_on      (trc_on),
    .dct_valid   (dct_valid),
    .dct_code    (dct_code),
    .flush       (flush),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_count (frame_count),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    dct_valid = 1'b1;
    dct_code  = c;
    tick();
    dct_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; trc_on = 1'b0; dct_valid = 1'b0; dct_code = 2'd0;
    flush = 1'b0; frame_ready = 1'b1;
    tick(); tick();
    chk("rst_count", 32'(dct_count), 0);
    chk("rst_buf", 32'(dct_buffer), 0);
    chk("rst_fvalid", 32'(frame_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_cnt), 0);

    reset = 1'b0; trc_on = 1'b1;
    tick();

    // Fill: 0,1,2,3,... into 15 slots
    for (int i = 0; i < 15; i++) begin
      send(2'(i % 4));
      if (i == 0) chk("acc_first", 32'(dct_count), 1);
    end
    chk("fill_fvalid", 32'(frame_valid), 1);
    chk("fill_data", 32'(frame_data), 32'h24E4E4E4);
    chk("fill_fcount", 32'(frame_count), 15);
    chk("fill_count0", 32'(dct_count), 0);
    tick();
    chk("fill_one_cycle", 32'(frame_valid), 0);

    // Partial flush
    send(2'd3); send(2'd2); send(2'd1);
    chk("pf_count", 32'(dct_count), 3);
    chk("pf_buf", 32'(dct_buffer), 32'h1B);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("pf_fvalid", 32'(frame_valid), 1);
    chk("pf_fcount", 32'(frame_count), 3);
    chk("pf_data", 32'(frame_data), 32'h1B);
    chk("pf_count0", 32'(dct_count), 0);
    tick();

    // Simultaneous code and flush at count 4
    send(2'd1); send(2'd1); send(2'd1); send(2'd1);
    flush = 1'b1; send(2'd2); flush = 1'b0;
    chk("sim_fcount", 32'(frame_count), 5);
    chk("sim_data", 32'(frame_data), 32'h255);
    tick();

    // Flush on empty accumulator with a code: accepted, no frame
    flush = 1'b1; send(2'd3); flush = 1'b0;
    chk("fe_fvalid", 32'(frame_valid), 0);
    chk("fe_count", 32'(dct_count), 1);
    chk("fe_buf", 32'(dct_buffer), 3);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fe_flush1", 32'(frame_count), 1);
    tick();

    // Trace off with 7 codes buffered
    for (int i = 0; i < 7; i++) send(2'd2);
    trc_on = 1'b0; tick();
    chk("to_fvalid", 32'(frame_valid), 1);
    chk("to_fcount", 32'(frame_count), 7);
    chk("to_data", 32'(frame_data), 32'h2AAA);
    send(2'd1); send(2'd1);
    chk("to_ignored", 32'(dct_count), 0);
    chk("to_fdone", 32'(frame_valid), 0);
    trc_on = 1'b1; tick();

    // Backpressure: 35 codes with downstream stalled
    frame_ready = 1'b0;
    for (int i = 0; i < 35; i++) send(2'(i % 4));
    chk("bp_drop", 32'(drop_cnt), 5);
    chk("bp_ovf", 32'(overflow), 1);
    chk("bp_count", 32'(dct_count), 15);
    chk("bp_f1_data", 32'(frame_data), 32'h24E4E4E4);
    chk("bp_f1_valid", 32'(frame_valid), 1);
    frame_ready = 1'b1; tick();
    chk("bp_f2_valid", 32'(frame_valid), 1);
    chk("bp_f2_data", 32'(frame_data), 32'h13939393);
    chk("bp_f2_fcount", 32'(frame_count), 15);
    chk("bp_acc_clr", 32'(dct_count), 0);
    tick();
    chk("bp_drained", 32'(frame_valid), 0);

    // Reset mid-operation
    for (int i = 0; i < 10; i++) send(2'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mr_count", 32'(dct_count), 0);
    chk("mr_buf", 32'(dct_buffer), 0);
    chk("mr_ovf", 32'(overflow), 0);
    chk("mr_drop", 32'(drop_cnt), 0);
    chk("mr_fvalid", 32'(frame_valid), 0);
    tick();
    chk("mr_nofr", 32'(frame_valid), 0);
    for (int i = 0; i < 15; i++) send(2'd3);
    chk("mr_f_valid", 32'(frame_valid), 1);
    chk("mr_f_data", 32'(frame_data), 32'h3FFFFFFF);
    chk("mr_f_fcount", 32'(frame_count), 15);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
